shift_deser_8_bit: RTL

Serial-to-parallel receiver that is the far end of the 8-bit universal shift register used as a serializer. It accepts one serial bit per qualified clock, in either LSB-first or MSB-first order, and assembles bytes in an internal shift register. Each completed byte is moved into a holding register and offered downstream on a valid/ready handshake. It sits between a serial link and the byte-wide datapath, and flags any byte lost to back-pressure.

---
 rtl/shift_deser_8_bit.sv | 104 ++++++++++
 1 files changed

// File: rtl/shift_deser_8_bit.sv
// Serial-to-parallel receiver: assembles WIDTH-bit words from a qualified bit
// stream (LSB- or MSB-first) and offers each word on a valid/ready holding register.
module shift_deser_8_bit #(
    parameter int  WIDTH = 8,
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             bit_valid,
    input  logic             dir,
    input  logic             frame_start,
    input  logic             data_ready,
    input  logic             clear_ovr,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             overrun,
    output logic             busy,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] shift_reg;
    logic             dir_q;

    logic [WIDTH-1:0] base_sr;
    logic [WIDTH-1:0] shift_right;
    logic [WIDTH-1:0] shift_left;
    logic [WIDTH-1:0] shift_next;
    logic [CNT_W-1:0] base_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             eff_dir;
    logic             dir_next;
    logic             complete;
    logic             load;
    logic             drop;

    // Both candidate shifts are built from the (possibly re-aligned) register.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == WIDTH - 1) begin : g_right_top
                assign shift_right[gi] = serial_in;
            end else begin : g_right_mid
                assign shift_right[gi] = base_sr[gi+1];
            end
            if (gi == 0) begin : g_left_bottom
                assign shift_left[gi] = serial_in;
            end else begin : g_left_mid
                assign shift_left[gi] = base_sr[gi-1];
            end
        end
    endgenerate

    always_comb begin
        base_sr    = frame_start ? '0 : shift_reg;
        base_cnt   = frame_start ? '0 : bit_cnt;
        // The first bit of a word (including one arriving with frame_start) latches dir.
        eff_dir    = (base_cnt == '0) ? dir : dir_q;
        shift_next = base_sr;
        cnt_next   = base_cnt;
        dir_next   = dir_q;
        complete   = 1'b0;
        if (bit_valid) begin
            dir_next   = eff_dir;
            shift_next = eff_dir ? shift_left : shift_right;
            complete   = (base_cnt == LAST_CNT);
            cnt_next   = complete ? '0 : base_cnt + CNT_W'(1);
        end
        load = complete && (!data_valid || data_ready);
        drop = complete && !load;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg  <= '0;
            dir_q      <= 1'b0;
            bit_cnt    <= '0;
            busy       <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            shift_reg <= shift_next;
            dir_q     <= dir_next;
            bit_cnt   <= cnt_next;
            busy      <= (cnt_next != '0);
            if (load) begin
                data_out   <= shift_next;
                data_valid <= 1'b1;
            end else if (data_ready) begin
                data_valid <= 1'b0;
            end
            // A drop on the same edge as clear_ovr wins.
            if (drop) begin
                overrun <= 1'b1;
            end else if (clear_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
